sar_adc_macro: RTL and testbench
================================

SAR_ADC_MACRO -- requirements
Module: sar_adc_macro

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of bits of the R2R DAC code and of the conversion result.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, minimum 1: number of clk cycles allowed for the DAC/comparator to settle per bit trial.
REQ-003 SHALL have port clk, input, 1 bit: single clock, 10 MHz nominal; all state on its rising edge.
REQ-004 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-high (a 1 resets the block).
REQ-005 SHALL have port start, input, 1 bit: request one conversion; sampled only in IDLE.
REQ-006 SHALL have port comp, input, 1 bit: external comparator output, asynchronous to clk; 1 means analog input >= DAC voltage.
REQ-007 SHALL have port dac, output, WIDTH bits: trial code driven to the R2R DAC.
REQ-008 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-009 SHALL have port valid, output, 1 bit: single-cycle pulse marking a new result.
REQ-010 SHALL have port result, output, WIDTH bits: last completed conversion code.

Function
REQ-011 SHALL pass comp through a 2-flop synchronizer before any use (comp_s); no other logic sees raw comp.
REQ-012 SHALL implement states IDLE and TRIAL; a bit index (WIDTH-1 down to 0) and a wait counter select the active trial.
REQ-013 In IDLE with start=1 at an edge, SHALL, at that edge: enter TRIAL, set bit index to WIDTH-1, dac = 1 followed by WIDTH-1 zeros (MSB only), busy=1, load wait counter.
REQ-014 Each bit trial SHALL last exactly T = SETTLE_CYCLES+2 cycles (settle plus synchronizer latency); comp_s is sampled on the T-th edge of the trial only.
REQ-015 At the deciding edge, SHALL keep the trial bit if comp_s=1, else clear it; for index>0, SHALL at the same edge set the next lower bit in dac and restart the wait counter.
REQ-016 At the deciding edge of bit 0, SHALL: write the final code to result, assert valid for exactly that following cycle, clear busy, return to IDLE; dac SHALL hold the final code.
REQ-017 Latency: start seen at edge E0 -> valid and new result visible after edge E0 + WIDTH*T (24 cycles at defaults); busy high for exactly WIDTH*T cycles.
REQ-018 start=1 during TRIAL SHALL be ignored (no restart, no queueing).
REQ-019 start held high through completion SHALL begin a new conversion at the first edge in IDLE (the cycle valid is high); back-to-back throughput one conversion per WIDTH*T+1 cycles.
REQ-020 comp changing mid-trial SHALL have no effect except through the value of comp_s at the deciding edge.
REQ-021 result SHALL change only at REQ-016 edges and otherwise hold its value, including while busy.
REQ-022 All-ones comparator SHALL yield result = all ones; all-zeros comparator SHALL yield result = 0.

Reset
REQ-023 n_rst=1 SHALL asynchronously force: state IDLE, dac=0, result=0, busy=0, valid=0, counters=0, synchronizer flops=0.
REQ-024 Reset asserted mid-conversion SHALL abort it; no valid pulse; after release, the block waits in IDLE for start.
REQ-025 First start SHALL be accepted at the first rising edge with n_rst=0.

Verification
REQ-026 Bench comparator model: comp = (dac <= VIN), VIN an integer code; WIDTH=4, SETTLE_CYCLES=4.
REQ-027 VIN=11, pulse start -> dac sequence 1000,1100,1010,1011 each held 6 cycles; result=1011, valid one cycle at E0+24, busy low after.
REQ-028 VIN=15 -> result=1111; VIN=0 -> result=0000; each with exactly one valid pulse.
REQ-029 start held high, VIN=5 -> conversions repeat every 25 cycles, each result=0101, valid pulses 25 cycles apart.
REQ-030 Reset at cycle 10 of a conversion (VIN=9) -> dac, busy, result immediately 0, no valid; new start after release -> result=1001.
REQ-031 start pulses at cycles 3 and 12 of a conversion (VIN=6) -> ignored; single result=0110 at E0+24.

Source files
------------

// File: rtl/sar_adc_macro.sv
// SAR ADC controller: comparator is double-synchronized, each bit trial takes SETTLE_CYCLES+2 clk cycles.
// Result and a one-cycle valid arrive WIDTH*(SETTLE_CYCLES+2) cycles after start; start is ignored while busy.
module sar_adc_macro #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic             comp,
   output logic [WIDTH-1:0] dac,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] result
);

   localparam int T  = SETTLE_CYCLES + 2;
   localparam int CW = (T > 1) ? $clog2(T) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [WIDTH-1:0] MSB_CODE  = WIDTH'(1) << (WIDTH - 1);
   localparam logic [CW-1:0]    WAIT_LOAD = CW'(T - 1);
   localparam logic [IW-1:0]    TOP_IDX   = IW'(WIDTH - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_TRIAL = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [1:0]       r_sync;
   logic             w_comp_s;

   logic [CW-1:0]    r_wait;
   logic [CW-1:0]    w_wait_nxt;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    w_idx_nxt;
   logic [IW-1:0]    w_idx_dn;
   logic [WIDTH-1:0] r_dac;
   logic [WIDTH-1:0] w_dac_nxt;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] w_result_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_valid;
   logic             w_valid_nxt;

   logic             w_decide;
   logic             w_last;

   // Raw comp is asynchronous to clk; only the second flop is ever observed.
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], comp};
      end
   end

   assign w_comp_s = r_sync[1];

   // The wait counter reaches zero on the last cycle of a trial, so the
   // deciding edge is the T-th edge after the trial code was applied.
   assign w_decide = (r_state == S_TRIAL) && (r_wait == '0);
   assign w_last   = (r_idx == '0);
   assign w_idx_dn = r_idx - IW'(1);

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_TRIAL;
            end
         end
         S_TRIAL: begin
            if (w_decide && w_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_dac_nxt    = r_dac;
      w_result_nxt = r_result;
      w_idx_nxt    = r_idx;
      w_wait_nxt   = r_wait;
      w_busy_nxt   = r_busy;
      w_valid_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_dac_nxt  = MSB_CODE;
               w_idx_nxt  = TOP_IDX;
               w_wait_nxt = WAIT_LOAD;
               w_busy_nxt = 1'b1;
            end
         end
         S_TRIAL: begin
            if (w_decide) begin
               w_dac_nxt[r_idx] = w_comp_s;
               if (w_last) begin
                  w_result_nxt = w_dac_nxt;
                  w_valid_nxt  = 1'b1;
                  w_busy_nxt   = 1'b0;
               end else begin
                  w_dac_nxt[w_idx_dn] = 1'b1;
                  w_idx_nxt           = w_idx_dn;
                  w_wait_nxt          = WAIT_LOAD;
               end
            end else begin
               w_wait_nxt = r_wait - CW'(1);
            end
         end
         default: begin
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         r_dac    <= '0;
         r_result <= '0;
         r_idx    <= '0;
         r_wait   <= '0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_dac    <= w_dac_nxt;
         r_result <= w_result_nxt;
         r_idx    <= w_idx_nxt;
         r_wait   <= w_wait_nxt;
         r_busy   <= w_busy_nxt;
         r_valid  <= w_valid_nxt;
      end
   end

   assign dac    = r_dac;
   assign busy   = r_busy;
   assign valid  = r_valid;
   assign result = r_result;

endmodule

// File: tb/tb_sar_adc_macro.sv
// Bench for sar_adc_macro: comparator modelled as (dac <= VIN), optional noise outside the sampled window.
// Expected codes come from a plain binary-search model of successive approximation.
module tb_sar_adc_macro;

   localparam int W = 4;
   localparam int S = 4;
   localparam int T = S + 2;

   logic         clk;
   logic         n_rst;
   logic         start;
   logic         comp;
   logic [W-1:0] dac;
   logic         busy;
   logic         valid;
   logic [W-1:0] result;

   int           vin;
   logic         noise;
   int           vectors;
   int           miscompares;
   int           cyc;
   int           last_valid_cyc;
   logic [W-1:0] prev_result;

   sar_adc_macro #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
      .clk    (clk),
      .n_rst  (n_rst),
      .start  (start),
      .comp   (comp),
      .dac    (dac),
      .busy   (busy),
      .valid  (valid),
      .result (result)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   assign comp = ((int'(dac) <= vin) ? 1'b1 : 1'b0) ^ noise;

   // Code on the DAC during trial j (j == W gives the final result):
   // each earlier bit is kept when the partial code still does not exceed v.
   function automatic logic [W-1:0] sar_code(input int v, input int j);
      int acc;
      int t;
      acc = 0;
      for (int i = 0; i < j; i++) begin
         t = acc + (1 << (W - 1 - i));
         if (t <= v) acc = t;
      end
      if (j < W) acc = acc + (1 << (W - 1 - j));
      return W'(acc);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launches (or continues, when start is already held) one conversion and
   // checks every cycle from the accepting edge E0 through E0+W*T.
   task automatic test_one_conversion(input int v, input bit hold, input bit ign, input bit glitch);
      logic [W-1:0] exp_code;
      logic [W-1:0] fin;
      fin   = sar_code(v, W);
      vin   = v;
      start = 1'b1;
      step();
      for (int k = 0; k <= T * W; k++) begin
         if (k < T * W) begin
            exp_code = sar_code(v, k / T);
            vectors++;
            if (dac !== exp_code) begin
               miscompares++;
               $display("FAIL trial_dac vin=%0d k=%0d got %b exp %b", v, k, dac, exp_code);
            end
            vectors++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
               miscompares++;
               $display("FAIL busy_valid_mid vin=%0d k=%0d got busy=%b valid=%b exp busy=1 valid=0", v, k, busy, valid);
            end
            vectors++;
            if (result !== prev_result) begin
               miscompares++;
               $display("FAIL result_hold vin=%0d k=%0d got %b exp %b", v, k, result, prev_result);
            end
            start = hold || (ign && (k == 3 || k == 12));
            noise = (glitch && (k % T) < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
         end else begin
            vectors++;
            if (valid !== 1'b1 || busy !== 1'b0) begin
               miscompares++;
               $display("FAIL done_flags vin=%0d got valid=%b busy=%b exp valid=1 busy=0", v, valid, busy);
            end
            vectors++;
            if (result !== fin || dac !== fin) begin
               miscompares++;
               $display("FAIL done_code vin=%0d got result=%b dac=%b exp %b", v, result, dac, fin);
            end
            last_valid_cyc = cyc;
            start = hold;
            noise = 1'b0;
         end
      end
      prev_result = fin;
      if (!hold) begin
         step();
         vectors++;
         if (valid !== 1'b0 || busy !== 1'b0 || dac !== fin || result !== fin) begin
            miscompares++;
            $display("FAIL after_done vin=%0d got valid=%b busy=%b dac=%b result=%b exp 0 0 %b %b",
                     v, valid, busy, dac, result, fin, fin);
         end
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b1;
      start = 1'b0;
      vin   = 0;
      noise = 1'b0;
      #1;
      vectors++;
      if (dac !== '0 || busy !== 1'b0 || valid !== 1'b0 || result !== '0) begin
         miscompares++;
         $display("FAIL reset_state got dac=%b busy=%b valid=%b result=%b exp all 0", dac, busy, valid, result);
      end
      step();
      step();
      vectors++;
      if (dac !== '0 || busy !== 1'b0 || valid !== 1'b0 || result !== '0) begin
         miscompares++;
         $display("FAIL reset_held got dac=%b busy=%b valid=%b result=%b exp all 0", dac, busy, valid, result);
      end
      prev_result = '0;
      n_rst = 1'b0;
   endtask

   // The first edge after release must already accept start.
   task automatic test_basic();
      vectors++;
      if (sar_code(11, 0) !== 4'b1000 || sar_code(11, 1) !== 4'b1100 ||
          sar_code(11, 2) !== 4'b1010 || sar_code(11, 4) !== 4'b1011) begin
         miscompares++;
         $display("FAIL model_vin11 got %b %b %b %b exp 1000 1100 1010 1011",
                  sar_code(11, 0), sar_code(11, 1), sar_code(11, 2), sar_code(11, 4));
      end
      test_one_conversion(11, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (result !== 4'b1011) begin
         miscompares++;
         $display("FAIL basic_result got %b exp 1011", result);
      end
   endtask

   task automatic test_extremes();
      test_one_conversion(15, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (result !== 4'b1111) begin
         miscompares++;
         $display("FAIL all_ones got %b exp 1111", result);
      end
      test_one_conversion(0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (result !== 4'b0000) begin
         miscompares++;
         $display("FAIL all_zeros got %b exp 0000", result);
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      int c1;
      test_one_conversion(5, 1'b1, 1'b0, 1'b0);
      c0 = last_valid_cyc;
      test_one_conversion(5, 1'b1, 1'b0, 1'b0);
      c1 = last_valid_cyc;
      vectors++;
      if (c1 - c0 != W * T + 1) begin
         miscompares++;
         $display("FAIL b2b_spacing got %0d exp %0d", c1 - c0, W * T + 1);
      end
      c0 = c1;
      test_one_conversion(5, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (last_valid_cyc - c0 != W * T + 1 || result !== 4'b0101) begin
         miscompares++;
         $display("FAIL b2b_last got spacing=%0d result=%b exp %0d 0101", last_valid_cyc - c0, result, W * T + 1);
      end
   endtask

   task automatic test_reset_mid();
      vin   = 9;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      n_rst = 1'b1;
      #1;
      vectors++;
      if (dac !== '0 || busy !== 1'b0 || result !== '0 || valid !== 1'b0) begin
         miscompares++;
         $display("FAIL async_abort got dac=%b busy=%b result=%b valid=%b exp all 0", dac, busy, result, valid);
      end
      step();
      step();
      n_rst       = 1'b0;
      prev_result = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         vectors++;
         if (busy !== 1'b0 || valid !== 1'b0 || dac !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset k=%0d got busy=%b valid=%b dac=%b exp 0 0 0000", k, busy, valid, dac);
         end
      end
      test_one_conversion(9, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (result !== 4'b1001) begin
         miscompares++;
         $display("FAIL reset_restart got %b exp 1001", result);
      end
   endtask

   task automatic test_ignore_start();
      test_one_conversion(6, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (result !== 4'b0110) begin
         miscompares++;
         $display("FAIL ignore_start got %b exp 0110", result);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         repeat ($urandom_range(0, 3)) step();
         test_one_conversion(int'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_glitch();
      for (int n = 0; n < 4; n++) begin
         test_one_conversion(int'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1);
      end
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      last_valid_cyc = 0;
      prev_result    = '0;
      test_reset();
      test_basic();
      test_extremes();
      test_back_to_back();
      test_reset_mid();
      test_ignore_start();
      test_random();
      test_glitch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
